muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with HI/LO registers for the MIPS core.
//  Sits downstream of the register file: consumes the read1/read2 operand values
//  for MULT/MULTU/DIV/DIVU/MTHI/MTLO, and supplies HI/LO for the MFHI/MFLO write-back mux.
//  Uses one shared shift datapath for both operations and runs 32 iterations per operation.
// PARAMETERS
//  WIDTH  32  operand width and HI/LO width; the iteration count equals WIDTH
// PORTS
//  clk     in   1        core clock (the divided out_clk)
//  rst     in   1        reset, asynchronous, active-low
//  start   in   1        operation request, sampled on the rising clk edge
//  op      in   3        0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
//  rs_val  in   WIDTH    operand A: multiplicand, dividend, or MTHI/MTLO data
//  rt_val  in   WIDTH    operand B: multiplier or divisor
//  busy    out  1        high while a multiply or divide is in progress
//  done    out  1        one-cycle pulse when HI/LO are updated by a multiply or divide
//  hi      out  WIDTH    HI register
//  lo      out  WIDTH    LO register
// BEHAVIOUR
//  - Clocking and reset: one clock domain.
//  - rst=0 clears, asynchronously: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, work regs=0.
//  - State machine: IDLE -> CALC -> FIX -> IDLE.
//  - IDLE:
//    - start=1 with op 0-3 latches operands and signs and loads the iteration counter with WIDTH.
//    - The state goes to CALC and busy=1 from that edge.
//    - Signed ops load |A| and |B| as unsigned values.
//  - IDLE, move ops: start=1 with op 4 writes hi<=rs_val; op 5 writes lo<=rs_val.
//    - The write completes in one edge; busy stays 0 and done stays 0.
//  - IDLE, reserved ops: start=1 with op 6 or 7 is ignored; there is no state change.
//  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge.
//    - The counter decrements on each step.
//    - After the WIDTH-th step the state goes to FIX.
//  - FIX:
//    - Applies the sign: product negated if signA^signB; quotient negated if signA^signB;
//      remainder takes the sign of the dividend.
//    - Writes hi/lo, sets done=1 for exactly one cycle, clears busy and returns to IDLE.
//  - Latency: start accepted at edge T; hi/lo valid and done=1 after edge T+WIDTH+1 (T+33).
//    - busy is high from T through T+WIDTH+1, exclusive of that last edge.
//  - Result mapping:
//    - Multiply: {hi,lo} = full 2*WIDTH product.
//    - Divide: lo = quotient, hi = remainder.
//  - start while busy=1 is ignored, for all ops including MTHI/MTLO.
//    - The upstream stalls until busy=0.
//  - hi/lo hold their old values during CALC; they change only in FIX or on an MTHI/MTLO edge.
//  - Divide by zero: no trap, runs the full latency.
//    - Result: lo = all ones, hi = rs_val.
//    - This holds for both signed and unsigned ops and ignores the sign fix.
//  - Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
//  - Unsigned abs: |0x80000000| is handled as unsigned 0x80000000; there is no overflow in the datapath.
//  - Reset mid-operation: the state aborts to IDLE immediately and hi/lo are cleared.
//    - No done pulse is produced.
//  - done and a new start may coincide: a start at the edge after done is accepted normally.
// TESTING
//  1. Reset clears all outputs: rst=0 mid-CALC -> busy=0, done=0, hi=0, lo=0 immediately, no later done.
//  2. Unsigned multiply: MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 cycles after start.
//  3. Signed multiply: MULT -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  4. Signed divide: DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     Unsigned divide: DIVU 7/2 -> lo=3, hi=1.
//  5. Divide by zero: DIV 0x12345678/0 -> lo=0xFFFFFFFF, hi=0x12345678.
//     Overflow: DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  6. Handshake: MTHI 0xA5A5A5A5 -> hi updated next edge, no busy or done.
//     MULTU start, then a second start of MTLO while busy -> the MTLO is ignored and lo = product low.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the operand read stage and the HI/LO unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// Works on magnitudes in a shared upper/lower shift register, one bit per
// cycle, and applies signs in a single fix-up cycle at the end.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt;
    logic             is_div, sign_a, sign_b, div_zero;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] upper, lower;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q;

    // Operand conditioning at request time; ops 0 and 2 are the signed ones.
    logic             start_calc, rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_abs, rt_abs;

    assign start_calc = (state_q == IDLE) && bus.start && !bus.op[2];
    assign rs_neg     = !bus.op[0] && bus.rs_val[WIDTH-1];
    assign rt_neg     = !bus.op[0] && bus.rt_val[WIDTH-1];
    assign rs_abs     = rs_neg ? -bus.rs_val : bus.rs_val;
    assign rt_abs     = rt_neg ? -bus.rt_val : bus.rt_val;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state: run until the counter hits its last step, then one fix-up cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_calc) state_d = CALC;
            CALC:    if (cnt == CW'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One iteration of the shared datapath: multiply shifts right with an
    // add of the multiplicand, divide shifts left with a restoring subtract.
    logic [WIDTH:0]   mul_sum, rem_sh, rem_sub;
    logic             rem_ge;
    logic [WIDTH-1:0] upper_nx, lower_nx;

    always_comb begin
        mul_sum = {1'b0, upper} + (lower[0] ? {1'b0, a_abs} : '0);
        rem_sh  = {upper, lower[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, b_abs};
        rem_ge  = rem_sh >= {1'b0, b_abs};
        if (is_div) begin
            upper_nx = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            lower_nx = {lower[WIDTH-2:0], rem_ge};
        end else begin
            upper_nx = mul_sum[WIDTH:1];
            lower_nx = {mul_sum[0], lower[WIDTH-1:1]};
        end
    end

    // Sign fix-up and result mapping. Divide by zero bypasses the sign logic:
    // the unsigned restoring loop already yields all-ones, and HI returns the raw dividend.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, hi_res, lo_res;

    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -{upper, lower} : {upper, lower};
        quo_fix  = (sign_a ^ sign_b) ? -lower : lower;
        rem_fix  = sign_a ? -upper : upper;
        hi_res   = prod_fix[2*WIDTH-1:WIDTH];
        lo_res   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                hi_res = sign_a ? -a_abs : a_abs;
                lo_res = '1;
            end else begin
                hi_res = rem_fix;
                lo_res = quo_fix;
            end
        end
    end

    // Datapath, counter, HI/LO and handshake registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            a_abs    <= '0;
            b_abs    <= '0;
            upper    <= '0;
            lower    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_calc) begin
                        is_div   <= bus.op[1];
                        sign_a   <= rs_neg;
                        sign_b   <= rt_neg;
                        div_zero <= (bus.rt_val == '0);
                        a_abs    <= rs_abs;
                        b_abs    <= rt_abs;
                        upper    <= '0;
                        lower    <= bus.op[1] ? rs_abs : rt_abs;
                        cnt      <= CW'(WIDTH);
                        busy_q   <= 1'b1;
                    end else if (bus.start && bus.op == 3'd4) begin
                        hi_q <= bus.rs_val;
                    end else if (bus.start && bus.op == 3'd5) begin
                        lo_q <= bus.rs_val;
                    end
                end
                CALC: begin
                    upper <= upper_nx;
                    lower <= lower_nx;
                    cnt   <= cnt - CW'(1);
                end
                FIX: begin
                    hi_q   <= hi_res;
                    lo_q   <= lo_res;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
